// File: rtl/booth_multi.sv
// booth_multi: sequential radix-2 Booth multiplier, signed N x N -> 2N, one Booth step per clock.
// Rev 1.0 - initial release.
`default_nettype none

module booth_multi #(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           sel,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] Z
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST_STEP = CW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [N:0]       m_q;
  logic [N:0]       acc_q;
  logic [N-1:0]     q_q;
  logic             qm1_q;
  logic [2*N-1:0]   z_q;

  logic [N:0]       sum_d;
  logic [N:0]       acc_d;
  logic [N-1:0]     q_d;
  logic             qm1_d;

  // One Booth step: conditional add/subtract of M, then arithmetic shift of {ACC,Q,Q_-1}.
  // ACC is one bit wider than the operand so ACC - (-2^(N-1)) never overflows.
  always_comb begin
    sum_d = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   sum_d = acc_q + m_q;
      2'b10:   sum_d = acc_q - m_q;
      default: sum_d = acc_q;
    endcase
    acc_d = {sum_d[N], sum_d[N:1]};
    q_d   = {sum_d[0], q_q[N-1:1]};
    qm1_d = q_q[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      z_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sel) begin
            m_q     <= {A[N-1], A};
            q_q     <= B;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          if (cnt_q == C_LAST_STEP) begin
            // Product is the low 2N bits of the shifted {ACC,Q}; sel during RUN is ignored.
            z_q     <= {acc_d[N-1:0], q_d};
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Z = z_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_multi.sv
// tb_booth_multi: scoreboard bench for booth_multi; expected products queued at capture, popped at completion.
`default_nettype none

module tb_booth_multi;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] Z;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] z_prev;

  booth_multi #(.N(8)) u_dut (
    .clock (clock),
    .reset (reset),
    .sel   (sel),
    .A     (A),
    .B     (B),
    .Z     (Z)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[15:0];
  endfunction

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %h expected <empty scoreboard>", tag, Z);
    end else begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check(tag, Z, e);
      z_prev = e;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete operation; optional disturbance of A and sel two edges into RUN.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit disturb);
    @(negedge clock);
    A   = a;
    B   = b;
    sel = 1'b1;
    tick();
    exp_q.push_back(prod(a, b));
    check({tag, "_capture_hold"}, Z, z_prev);
    @(negedge clock);
    sel = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (disturb && i == 2) begin
        @(negedge clock);
        A   = 8'h55;
        sel = 1'b1;
        tick();
        @(negedge clock);
        sel = 1'b0;
      end else begin
        tick();
      end
      if (i == 4 || i == 7) check({tag, "_run_hold"}, Z, z_prev);
    end
    tick();
    pop_check(tag);
  endtask

  initial begin
    reset  = 1'b1;
    sel    = 1'b1;
    A      = 8'd3;
    B      = 8'd5;
    z_prev = 16'h0000;

    tick();
    tick();
    check("reset_z", Z, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    sel   = 1'b0;
    repeat (10) tick();
    check("reset_no_start", Z, 16'h0000);

    run_op("pos_3x5", 8'd3, 8'd5, 1'b0);
    repeat (3) tick();
    check("pos_hold_idle", Z, 16'h000F);

    run_op("neg7x6", 8'hF9, 8'd6, 1'b0);
    run_op("6xneg7", 8'd6, 8'hF9, 1'b0);
    run_op("m128xm128", 8'h80, 8'h80, 1'b0);
    run_op("m128x127", 8'h80, 8'h7F, 1'b0);
    run_op("127x127", 8'h7F, 8'h7F, 1'b0);
    run_op("m1xm1", 8'hFF, 8'hFF, 1'b0);
    run_op("zero_a", 8'h00, 8'h9C, 1'b0);
    run_op("zero_b", 8'h33, 8'h00, 1'b0);

    run_op("isolate", 8'd10, 8'd10, 1'b1);
    repeat (10) tick();
    check("isolate_no_queue", Z, 16'h0064);

    for (int r = 0; r < 6; r++) begin
      run_op("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    end

    // sel held high: restart on the first idle edge after completion.
    @(negedge clock);
    A   = 8'd5;
    B   = 8'hFD;
    sel = 1'b1;
    tick();
    exp_q.push_back(prod(8'd5, 8'hFD));
    repeat (8) tick();
    pop_check("held_first");
    @(negedge clock);
    A = 8'd7;
    tick();
    exp_q.push_back(prod(8'd7, 8'hFD));
    repeat (7) tick();
    check("held_hold", Z, z_prev);
    tick();
    pop_check("held_restart");
    @(negedge clock);
    A = 8'd5;
    tick();
    exp_q.push_back(prod(8'd5, 8'hFD));
    repeat (8) tick();
    pop_check("held_const1");
    repeat (9) tick();
    check("held_const2", Z, 16'hFFF1);
    @(negedge clock);
    sel = 1'b0;
    repeat (10) tick();

    // Reset on the 4th RUN edge aborts the operation.
    @(negedge clock);
    A   = 8'd12;
    B   = 8'hFD;
    sel = 1'b1;
    tick();
    @(negedge clock);
    sel = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("midrun_reset_z", Z, 16'h0000);
    z_prev = 16'h0000;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) tick();
    check("midrun_aborted", Z, 16'h0000);
    run_op("after_reset_2x2", 8'd2, 8'd2, 1'b0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/booth_multi.md
Name: booth_multi

Overview:
- Sequential radix-2 Booth multiplier for signed two's-complement operands. Multiplies an 8-bit A by an 8-bit B and gives a 16-bit signed product Z.
- Used as the per-tap product engine in the linear-convolution datapath. Each convolution output group starts its multipliers with a shared `sel` strobe, then sums their Z outputs combinationally.
- Z holds the last completed product until the next one finishes.

Parameters:
- N, 8: operand width in bits. Product width is 2N. All behaviour below is stated for N=8.

Ports:
- clock  input  1   rising-edge clock.
- reset  input  1   synchronous, active-high reset.
- sel    input  1   start request; level, sampled on the rising edge of `clock` while idle.
- A      input  8   signed multiplicand.
- B      input  8   signed multiplier.
- Z      output 16  signed product A*B; registered.

Behaviour:
- Reset: on a rising edge with reset=1:
  - Z=0, state=IDLE, iteration counter=0, all internal registers 0.
  - Reset overrides `sel` and aborts any operation in progress.
- States: IDLE and RUN.
- IDLE:
  - Rising edge with sel=1: capture M=A (sign-extended to 9 bits), Q=B, accumulator ACC(9 bits)=0, Q_-1=0, count=0; go to RUN.
  - sel=0: stay in IDLE.
  - Z is unchanged on the capture edge.
- RUN: each rising edge performs one Booth step.
  - Pair {Q[0],Q_-1} selects the ACC update: 01 → ACC=ACC+M; 10 → ACC=ACC-M; 00 or 11 → no change.
  - Then arithmetic right shift of {ACC,Q,Q_-1} by one; ACC MSB is replicated.
  - count increments.
- Completion:
  - On the 8th RUN edge: Z <= low 16 bits of the shifted {ACC,Q} (the full product); go to IDLE.
  - Latency: `sel` captured at edge k → Z valid after edge k+8.
  - A new start can be captured at edge k+9.
- Arithmetic:
  - 9-bit ACC so that subtracting M=-128 cannot overflow.
  - All 8-bit operand pairs give an exact result. Range is -16256..16384; 16384 (−128×−128) is representable as 0x4000.
- Z holds its value in IDLE and throughout RUN. It changes only on a completion edge or on reset.
- Boundary conditions:
  - `sel` asserted during RUN is ignored. No queuing.
  - Changes on A or B during RUN do not affect the current result; operands are latched at start.
  - `sel` held high continuously: a new operation restarts on the first IDLE edge after each completion. With constant A and B, Z stays stable at the same product.
  - Reset asserted mid-operation: Z=0 and state=IDLE on that edge. The aborted result is never written.
  - Zero operand (A=0 or B=0): Z=0 after the normal 8-cycle latency. There is no early termination; latency is fixed at 8.

Test Plan:
- Reset: hold reset for 2 edges with sel=1 → Z=0x0000, and no operation starts while reset=1.
- Basic positive: A=3, B=5, sel high for 1 cycle → Z stays 0x0000 for 7 edges, then Z=15 (0x000F) after the 8th RUN edge, then holds.
- Mixed sign: A=-7 (0xF9), B=6 → Z=-42 (0xFFD6); A=6, B=-7 → Z=0xFFD6.
- Extremes:
  - A=-128, B=-128 → 0x4000.
  - A=-128, B=127 → -16256 (0xC080).
  - A=127, B=127 → 16129 (0x3F01).
  - A=-1, B=-1 → 0x0001.
- Operand isolation: start A=10, B=10, change A to 0x55 and pulse sel during RUN → Z=100 (0x0064); the second sel pulse is ignored.
- Reset mid-run: start A=12, B=-3, assert reset at the 4th RUN edge → Z=0 and IDLE. A subsequent start with A=2, B=2 → Z=4 after 8 edges.
